// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a one-cycle-latency
// instruction memory, buffers {pc, inst} pairs and presents the head to decode.
module fetch_queue #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       im_read,
    output logic [PC_W-1:0]            im_addr,
    input  logic [INST_W-1:0]          im_inst,
    input  logic                       flush,
    input  logic [PC_W-1:0]            new_addr,
    input  logic                       id_stall,
    output logic                       id_valid,
    output logic [PC_W-1:0]            id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH):0]     fq_count,
    output logic                       fq_full,
    output logic                       fq_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   r_fpc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_inflight;
    logic [PC_W-1:0]   r_inflight_addr;
    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];

    logic [CNT_W:0]    w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_has_entry;

    // Outstanding request counts as occupied so its response always has a free slot.
    assign w_occupancy = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
    assign w_issue     = w_occupancy < (CNT_W+1)'(DEPTH);
    assign w_has_entry = (r_count != '0);
    assign w_push      = r_inflight && !flush;
    assign w_pop       = w_has_entry && !id_stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc           <= RESET_PC;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (flush) begin
            r_fpc           <= new_addr + PC_W'(PC_STEP);
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b1;
            r_inflight_addr <= new_addr;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fpc           <= r_fpc + PC_W'(PC_STEP);
                r_inflight_addr <= r_fpc;
            end
        end
    end

    // NOTE: storage has no reset; r_count alone decides whether an entry is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_inflight_addr;
            r_mem_inst[r_wr_ptr] <= im_inst;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        im_read  = 1'b0;
        im_addr  = r_fpc;
        id_valid = 1'b0;
        id_pc    = '0;
        id_inst  = NOP_INST;
        fq_count = '0;
        fq_full  = 1'b0;
        fq_empty = 1'b1;
        if (!rst) begin
            im_read  = flush || w_issue;
            im_addr  = flush ? new_addr : r_fpc;
            id_valid = w_has_entry;
            fq_count = r_count;
            fq_full  = (r_count == CNT_W'(DEPTH));
            fq_empty = !w_has_entry;
            if (w_has_entry) begin
                id_pc   = r_mem_pc[r_rd_ptr];
                id_inst = r_mem_inst[r_rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a behavioural model holds the expected
// queue of fetched PCs; entries are pushed on responses and popped on decode.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        im_read;
    logic [31:0] im_addr;
    logic [31:0] im_inst = '0;
    logic        flush = 1'b0;
    logic [31:0] new_addr = '0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  fq_count;
    logic        fq_full;
    logic        fq_empty;

    fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .PC_STEP(4),
                  .RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .clk(clk), .rst(rst), .im_read(im_read), .im_addr(im_addr),
        .im_inst(im_inst), .flush(flush), .new_addr(new_addr),
        .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .fq_count(fq_count), .fq_full(fq_full),
        .fq_empty(fq_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_fpc = 32'h0;
    logic        m_inflight = 1'b0;
    logic [31:0] m_iaddr = 32'h0;
    int          max_cnt;
    logic        seen_200;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
    task automatic cycle(input logic r, input logic f, input logic [31:0] na, input logic s);
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        @(negedge clk);
        rst      = r;
        flush    = f;
        new_addr = na;
        id_stall = s;
        im_inst  = m_inflight ? inst_of(m_iaddr) : 32'hDEAD_BEEF;
        #1;
        e_read  = !r && (f || (m_q.size() + int'(m_inflight) < DEPTH));
        e_addr  = f ? na : m_fpc;
        e_valid = !r && (m_q.size() > 0);
        e_pc    = e_valid ? m_q[0] : 32'h0;
        check("im_read", 32'(im_read), 32'(e_read));
        if (e_read) check("im_addr", im_addr, e_addr);
        check("id_valid", 32'(id_valid), 32'(e_valid));
        check("id_pc", id_pc, e_pc);
        check("id_inst", id_inst, e_valid ? inst_of(e_pc) : 32'h0);
        check("fq_count", 32'(fq_count), r ? 32'd0 : 32'(m_q.size()));
        check("fq_full", 32'(fq_full), 32'(!r && m_q.size() == DEPTH));
        check("fq_empty", 32'(fq_empty), 32'(r || m_q.size() == 0));
        if (int'(fq_count) > max_cnt) max_cnt = int'(fq_count);
        if (id_valid && id_pc == 32'h200) seen_200 = 1'b1;
        if (r) begin
            m_q.delete();
            m_fpc      = 32'h0;
            m_inflight = 1'b0;
        end else if (f) begin
            m_q.delete();
            m_fpc      = na + 32'd4;
            m_inflight = 1'b1;
            m_iaddr    = na;
        end else begin
            if (e_valid && !s) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_iaddr);
            m_inflight = e_read;
            if (e_read) begin
                m_iaddr = m_fpc;
                m_fpc   = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n, input logic s);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, s);
    endtask

    task automatic fill_to(input int target);
        int k;
        k = 0;
        while (m_q.size() < target && k < 20) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            k++;
        end
        check("fill_timeout", 32'(m_q.size()), 32'(target));
    endtask

    initial begin
        max_cnt  = 0;
        seen_200 = 1'b0;

        // Reset state, then streaming without stall
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h40, 1'b0);
        max_cnt = 0;
        run(14, 1'b0);
        check("stream_max_count", 32'(max_cnt <= 2), 32'd1);

        // Stall back-pressure from reset, then release
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run(10, 1'b1);
        check("stall_full", 32'(fq_full), 32'd1);
        check("stall_count", 32'(fq_count), 32'd4);
        check("stall_no_read", 32'(im_read), 32'd0);
        check("stall_head", id_pc, 32'h0);
        run(8, 1'b0);

        // Flush while holding three entries
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        fill_to(3);
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_empty", 32'(id_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_head", id_pc, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_next", id_pc, 32'h104);

        // Flush wins over stall with a full queue
        fill_to(DEPTH);
        cycle(1'b0, 1'b1, 32'h180, 1'b1);
        run(3, 1'b1);
        run(5, 1'b0);

        // Back-to-back flushes
        seen_200 = 1'b0;
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        cycle(1'b0, 1'b1, 32'h300, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("b2b_first", id_pc, 32'h300);
        run(6, 1'b0);
        check("b2b_no_200", 32'(seen_200), 32'd0);

        // Reset mid-stream with a request in flight
        check("pre_rst_inflight", 32'(m_inflight), 32'd1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_restart", im_addr, 32'h0);
        run(6, 1'b0);

        // Random stalls and flushes
        for (int i = 0; i < 300; i++) begin
            logic f;
            f = ($urandom_range(0, 15) == 0);
            cycle(($urandom_range(0, 99) == 0), f,
                  {20'h0, 10'($urandom), 2'b00}, ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter / instruction-address width.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; legal range 2..16, power of two.
REQ-004 SHALL have parameter PC_STEP, default 4, meaning sequential address increment.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-006 SHALL have parameter NOP_INST, default 0, meaning value driven on id_inst when id_valid=0.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 im_read  output  1  fetch request to instruction memory this cycle.
REQ-010 im_addr  output  PC_W  fetch address; meaningful only when im_read=1.
REQ-011 im_inst  input  INST_W  instruction word, valid exactly one cycle after the im_read that requested it.
REQ-012 flush  input  1  redirect request (taken branch).
REQ-013 new_addr  input  PC_W  redirect target; sampled when flush=1.
REQ-014 id_stall  input  1  decode stage cannot accept; hold head entry.
REQ-015 id_valid  output  1  head entry present.
REQ-016 id_pc  output  PC_W  address of head instruction.
REQ-017 id_inst  output  INST_W  head instruction word.
REQ-018 fq_count  output  $clog2(DEPTH)+1  current occupied entries.
REQ-019 fq_full / fq_empty  output  1 each  count==DEPTH / count==0.

Function
REQ-020 SHALL hold a fetch PC register (fpc), DEPTH-entry storage of {pc, inst}, read/write pointers wrapping modulo DEPTH, a count, and a 1-bit inflight register with its captured address.
REQ-021 Issue: when flush=0, im_read SHALL be 1 iff count+inflight < DEPTH; im_addr=fpc; on issue fpc SHALL advance by PC_STEP (modulo 2^PC_W) and inflight SHALL be set, else cleared.
REQ-022 Response: when inflight=1 and flush=0, im_inst with the captured address SHALL be written at the write pointer at the next edge.
REQ-023 Pop: SHALL occur when id_valid=1 and id_stall=0 and flush=0; read pointer advances at the edge.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push into a full queue cannot occur (guaranteed by REQ-021).
REQ-025 Output: id_valid = !fq_empty; id_pc/id_inst = head entry; when empty id_pc=0 and id_inst=NOP_INST; outputs SHALL stay stable while id_stall=1.
REQ-026 Flush (priority over push, pop, stall): in the flush cycle im_read=1, im_addr=new_addr; the response arriving in the flush cycle SHALL be discarded; at the edge count=0, pointers=0, fpc=new_addr+PC_STEP, inflight=1 with address new_addr.
REQ-027 Latency: request at cycle N -> entry visible (id_valid=1) at cycle N+2; flush at cycle N -> id_pc=new_addr at cycle N+2.
REQ-028 Throughput: one instruction per cycle sustained when DEPTH>=3 and id_stall=0.
REQ-029 Stall back-pressure: with id_stall=1 the queue fills to DEPTH and im_read drops to 0; no entry is lost or duplicated.

Reset
REQ-030 When rst=1 at an edge: fpc=RESET_PC, count=0, pointers=0, inflight=0; rst SHALL override flush and any in-flight response.
REQ-031 During reset cycle outputs SHALL be im_read=0, id_valid=0, id_pc=0, id_inst=NOP_INST, fq_count=0, fq_empty=1, fq_full=0.
REQ-032 First cycle after rst deasserts SHALL issue im_read=1, im_addr=RESET_PC.

Verification
REQ-033 Reset then no stall, IM returns addr-based words -> id_pc sequence 0,4,8,12... from cycle 2, one per cycle, fq_count never exceeds 2.
REQ-034 id_stall=1 held 10 cycles after reset -> fq_count reaches 4, fq_full=1, im_read=0, id_pc stays 0; release -> 0,4,8,12,16 in order, no gaps.
REQ-035 flush=1, new_addr=0x100 while queue holds 3 entries -> next cycle fq_count=0, id_valid=0; cycle after id_pc=0x100, then 0x104.
REQ-036 flush asserted concurrently with id_stall=1 and full queue -> flush wins; stale entries never appear on id_pc.
REQ-037 Back-to-back flushes to 0x200 then 0x300 -> 0x200 never reaches id_pc; first valid id_pc=0x300.
REQ-038 rst asserted mid-stream with inflight=1 -> after release fetch restarts at RESET_PC; no pre-reset instruction emerges.
